// File: rtl/key_expansion_ctrl.sv
// Iterative AES-128 key-expansion controller: expands one cipher key into
// NUM_ROUNDS+1 round keys (one per cycle) and serves them through a registered read port.
module key_expansion_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key,
  output logic [3:0]   avail,
  output logic         busy,
  output logic         keys_ready,
  output logic         done
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the AES affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
    x2   = gmul(x, x);
    x4   = gmul(x2, x2);
    x8   = gmul(x4, x4);
    x16  = gmul(x8, x8);
    x32  = gmul(x16, x16);
    x64  = gmul(x32, x32);
    x128 = gmul(x64, x64);
    inv  = gmul(gmul(gmul(x2, x4), gmul(x8, x16)), gmul(gmul(x32, x64), x128));
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // One AES-128 key-schedule round; word w sits at [32w+31:32w], byte 0 lowest
  function automatic logic [127:0] key_schedule(input logic [127:0] k, input logic [31:0] rcon);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {k[103:96], k[127:104]};
    t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ rcon;
    w0 = k[31:0]   ^ t;
    w1 = k[63:32]  ^ w0;
    w2 = k[95:64]  ^ w1;
    w3 = k[127:96] ^ w2;
    return {w3, w2, w1, w0};
  endfunction

  state_t         state_q;
  logic           key_ready_q;
  logic           busy_q;
  logic           keys_ready_q;
  logic           done_q;
  logic [3:0]     avail_q;
  logic [3:0]     cnt_q;
  logic [7:0]     rc_q;
  logic [127:0]   cur_q;
  logic [127:0]   rd_key_q;
  logic [127:0]   store_q [0:NUM_ROUNDS];

  logic [127:0]   ks_d;
  logic [7:0]     rc_d;
  logic           load_s;

  assign ks_d   = key_schedule(cur_q, {24'h000000, rc_q});
  assign rc_d   = xtime(rc_q);
  assign load_s = key_valid & key_ready_q;

  // Control FSM with registered status outputs and the read-port register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      key_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      keys_ready_q <= 1'b0;
      done_q       <= 1'b0;
      avail_q      <= 4'd0;
      cnt_q        <= 4'd0;
      rc_q         <= 8'h00;
      cur_q        <= 128'h0;
      rd_key_q     <= 128'h0;
    end else begin
      done_q   <= 1'b0;
      rd_key_q <= (rd_idx <= LAST_IDX) ? store_q[rd_idx] : 128'h0;
      case (state_q)
        IDLE: begin
          if (load_s) begin
            state_q      <= EXPAND;
            key_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            keys_ready_q <= 1'b0;
            cur_q        <= key_in;
            rc_q         <= 8'h01;
            cnt_q        <= 4'd1;
            avail_q      <= 4'd1;
          end else begin
            state_q <= IDLE;
          end
        end
        EXPAND: begin
          cur_q   <= ks_d;
          rc_q    <= rc_d;
          cnt_q   <= cnt_q + 4'd1;
          avail_q <= avail_q + 4'd1;
          // the edge that writes the last slot also completes the expansion
          if (cnt_q == LAST_IDX) begin
            state_q      <= IDLE;
            key_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            keys_ready_q <= 1'b1;
            done_q       <= 1'b1;
          end else begin
            state_q <= EXPAND;
          end
        end
        default: begin
          state_q     <= IDLE;
          key_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Round-key store; contents survive reset, validity is tracked by avail
  always_ff @(posedge clk) begin
    if (load_s && (state_q == IDLE)) begin
      store_q[0] <= key_in;
    end else if (state_q == EXPAND) begin
      store_q[cnt_q] <= ks_d;
    end
  end

  assign key_ready  = key_ready_q;
  assign busy       = busy_q;
  assign keys_ready = keys_ready_q;
  assign done       = done_q;
  assign avail      = avail_q;
  assign rd_key     = rd_key_q;

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Scoreboard bench for key_expansion_ctrl against a FIPS-197 word-array reference model.
module tb_key_expansion_ctrl;

  localparam int N = 10;

  typedef struct {
    logic [127:0] val;
    logic [127:0] mask;
    int           tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic [3:0]   avail;
  logic         busy;
  logic         keys_ready;
  logic         done;

  logic         k1_valid;
  logic         k1_ready;
  logic [127:0] k1_in;
  logic [3:0]   rd1_idx;
  logic [127:0] rd1_key;
  logic [3:0]   avail1;
  logic         busy1;
  logic         keys_ready1;
  logic         done1;

  int           checks = 0;
  int           errors = 0;
  logic [7:0]   sbox_t [0:255];
  logic [127:0] mdl_rk [0:10];
  logic [127:0] prev_rk [0:10];
  logic [127:0] cur_rk [0:10];
  logic         rd_chk = 1'b0;
  logic         rd_chk_d = 1'b0;
  exp_t         exp_q[$];
  exp_t         mon_e;

  localparam logic [127:0] FULL = {128{1'b1}};

  always #5 clk = ~clk;

  key_expansion_ctrl #(.NUM_ROUNDS(N)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
    .rd_idx(rd_idx), .rd_key(rd_key), .avail(avail), .busy(busy),
    .keys_ready(keys_ready), .done(done)
  );

  key_expansion_ctrl #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .key_valid(k1_valid), .key_ready(k1_ready), .key_in(k1_in),
    .rd_idx(rd1_idx), .rd_key(rd1_key), .avail(avail1), .busy(busy1),
    .keys_ready(keys_ready1), .done(done1)
  );

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: a read issued before an edge is compared at the following negedge
  always @(posedge clk) rd_chk_d <= rd_chk;

  always @(negedge clk) begin
    if (rd_chk_d) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %h expected no read", rd_key);
      end else begin
        mon_e = exp_q.pop_front();
        if ((rd_key & mon_e.mask) !== (mon_e.val & mon_e.mask)) begin
          errors++;
          $display("FAIL rd_tag%0d: got %h expected %h (mask %h)", mon_e.tag, rd_key, mon_e.val, mon_e.mask);
        end
      end
    end
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = 15'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  // FIPS-197 order: byte 0 of the key is the most significant byte of literal f
  function automatic logic [127:0] fips2dut(input logic [127:0] f);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[8*b +: 8] = f[120 - 8*b +: 8];
    return r;
  endfunction

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon_t [0:9];
    rcon_t = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++)
      w[i] = {key[32*i +: 8], key[32*i+8 +: 8], key[32*i+16 +: 8], key[32*i+24 +: 8]};
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rcon_t[i/4 - 1], 24'h000000};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      for (int c = 0; c < 4; c++)
        mdl_rk[r][32*c +: 32] = {w[4*r+c][7:0], w[4*r+c][15:8], w[4*r+c][23:16], w[4*r+c][31:24]};
  endtask

  // Store contents seen at edge E0+j: slots below j already hold the new key
  function automatic logic [127:0] exp_slot(input int s, input int j);
    if (s > N) return 128'h0;
    else if (s < j) return cur_rk[s];
    else return prev_rk[s];
  endfunction

  task automatic next_cycle();
    @(negedge clk);
    rd_chk = 1'b0;
  endtask

  task automatic issue_read(input int idx, input logic [127:0] val, input logic [127:0] mask, input int tag);
    exp_t e;
    rd_idx = 4'(idx);
    rd_chk = 1'b1;
    e.val  = val;
    e.mask = mask;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic do_load(input logic [127:0] k, input logic hold, input logic [127:0] other, input logic rd);
    for (int r = 0; r <= 10; r++) prev_rk[r] = cur_rk[r];
    model_expand(k);
    for (int r = 0; r <= 10; r++) cur_rk[r] = mdl_rk[r];
    key_valid = 1'b1;
    key_in    = k;
    if (rd) issue_read(0, exp_slot(0, 0), FULL, 100);
    next_cycle();
    key_valid = hold;
    key_in    = other;
    chk("load_avail", avail, 1);
    chk("load_busy", busy, 1);
    chk("load_key_ready", key_ready, 0);
    chk("load_keys_ready", keys_ready, 0);
    chk("load_done", done, 0);
    for (int j = 1; j <= N; j++) begin
      if (rd) issue_read(j, exp_slot(j, j), FULL, 200 + j);
      next_cycle();
      chk("exp_avail", avail, j + 1);
      chk("exp_done", done, j == N);
      chk("exp_key_ready", key_ready, j == N);
      chk("exp_busy", busy, j != N);
      chk("exp_keys_ready", keys_ready, j == N);
    end
  endtask

  task automatic idle_after_done();
    next_cycle();
    chk("idle_done", done, 0);
    chk("idle_keys_ready", keys_ready, 1);
    chk("idle_key_ready", key_ready, 1);
    chk("idle_avail", avail, N + 1);
  endtask

  task automatic read_all(input int tagbase);
    for (int s = 0; s < 16; s++) begin
      issue_read(s, exp_slot(s, 99), FULL, tagbase + s);
      next_cycle();
    end
  endtask

  logic [127:0] fips_key, fips_s1, fips_s10, ka, kb;

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_in = 128'h0; rd_idx = 4'd0;
    k1_valid = 1'b0; k1_in = 128'h0; rd1_idx = 4'd0;
    build_sbox();
    fips_key = fips2dut(128'h2b7e151628aed2a6abf7158809cf4f3c);
    fips_s1  = fips2dut(128'ha0fafe1788542cb123a339392a6c7605);
    fips_s10 = fips2dut(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    @(negedge clk);
    chk("rst_key_ready", key_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_keys_ready", keys_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_avail", avail, 0);
    chk("rst_rd_key", rd_key, 0);
    rst = 1'b0;
    next_cycle();
    chk("idle_key_ready0", key_ready, 1);

    // FIPS-197 vector
    do_load(fips_key, 1'b0, 128'h0, 1'b0);
    idle_after_done();
    issue_read(1, fips_s1, FULL, 1);
    next_cycle();
    issue_read(10, fips_s10, FULL, 2);
    next_cycle();
    read_all(300);

    // key_valid held through expansion; second key accepted right after done
    ka = {$urandom(), $urandom(), $urandom(), $urandom()};
    kb = {$urandom(), $urandom(), $urandom(), $urandom()};
    do_load(ka, 1'b1, kb, 1'b1);
    do_load(kb, 1'b0, 128'h0, 1'b1);
    idle_after_done();
    read_all(400);

    // reset in the middle of an expansion
    rd_idx    = 4'd0;
    key_valid = 1'b1;
    key_in    = fips_key;
    next_cycle();
    key_valid = 1'b0;
    repeat (4) next_cycle();
    chk("pre_rst_avail", avail, 5);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_avail", avail, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_keys_ready", keys_ready, 0);
    chk("mid_rst_rd_key", rd_key, 0);
    chk("mid_rst_key_ready", key_ready, 1);
    #1 rst = 1'b0;
    next_cycle();
    do_load(fips_key, 1'b0, 128'h0, 1'b0);
    idle_after_done();
    issue_read(1, fips_s1, FULL, 3);
    next_cycle();
    issue_read(10, fips_s10, FULL, 4);
    next_cycle();
    read_all(500);

    // all-zero key exercises every rcon step
    do_load(128'h0, 1'b0, 128'h0, 1'b1);
    idle_after_done();
    issue_read(1, fips2dut(128'h62636363626363636263636362636363), FULL, 5);
    next_cycle();
    issue_read(10, fips2dut(128'hb4ef5bcb000000000000000000000000), 128'hffffffff, 6);
    next_cycle();
    read_all(600);

    // random keys with reads during expansion and random idle reads
    for (int n = 0; n < 4; n++) begin
      ka = {$urandom(), $urandom(), $urandom(), $urandom()};
      do_load(ka, 1'b0, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
      idle_after_done();
      for (int r = 0; r < 12; r++) begin
        int idx;
        idx = int'($urandom_range(0, 15));
        issue_read(idx, exp_slot(idx, 99), FULL, 700 + 20*n + r);
        next_cycle();
      end
    end

    // single-round instance
    chk("n1_key_ready_idle", k1_ready, 1);
    k1_valid = 1'b1;
    k1_in    = fips_key;
    next_cycle();
    k1_valid = 1'b0;
    chk("n1_avail_e0", avail1, 1);
    chk("n1_busy_e0", busy1, 1);
    chk("n1_done_e0", done1, 0);
    next_cycle();
    chk("n1_done_e1", done1, 1);
    chk("n1_avail_e1", avail1, 2);
    chk("n1_keys_ready", keys_ready1, 1);
    chk("n1_busy_e1", busy1, 0);
    chk("n1_key_ready_e1", k1_ready, 1);
    rd1_idx = 4'd1;
    next_cycle();
    chk("n1_done_drop", done1, 0);
    chk("n1_slot1", rd1_key, fips_s1);
    rd1_idx = 4'd2;
    next_cycle();
    chk("n1_idx2_zero", rd1_key, 0);

    repeat (2) next_cycle();
    chk("sb_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
